// File: rtl/seq_restoring_divider_pkg.sv
// Shared definitions for the sequential restoring divider: state encoding,
// default operand widths and the iteration-counter width helper.
package seq_restoring_divider_pkg;

    localparam int DEF_DIVIDEND_W = 8;
    localparam int DEF_DIVISOR_W  = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // One extra bit over $clog2 so the counter can reach DIVIDEND_W without wrapping.
    function automatic int cnt_width(input int n);
        return $clog2(n) + 1;
    endfunction

endpackage

// File: rtl/seq_restoring_divider_div_step.sv
// One restoring-division iteration: shift the next dividend bit into the
// partial remainder, trial-subtract the divisor, and shift the quotient bit in.
module div_step
    import seq_restoring_divider_pkg::*;
#(
    parameter int DIVIDEND_W = DEF_DIVIDEND_W,
    parameter int DIVISOR_W  = DEF_DIVISOR_W
) (
    input  logic [DIVISOR_W-1:0]  i_rem,
    input  logic [DIVIDEND_W-1:0] i_q,
    input  logic [DIVISOR_W-1:0]  i_divisor,
    output logic [DIVISOR_W-1:0]  o_rem,
    output logic [DIVIDEND_W-1:0] o_q
);

    // The stored remainder is always below the divisor, so it fits DIVISOR_W
    // bits; only the shifted trial value R' needs the extra top bit.
    logic [DIVISOR_W:0] w_shift;
    logic [DIVISOR_W:0] w_div_ext;

    assign w_shift   = {i_rem, i_q[DIVIDEND_W-1]};
    assign w_div_ext = {1'b0, i_divisor};

    // Trial subtraction; the modular DIVISOR_W-bit difference is exact because the result is below the divisor.
    always_comb begin
        o_rem = w_shift[DIVISOR_W-1:0];
        o_q   = {i_q[DIVIDEND_W-2:0], 1'b0};
        if (w_shift >= w_div_ext) begin
            o_rem = w_shift[DIVISOR_W-1:0] - i_divisor;
            o_q   = {i_q[DIVIDEND_W-2:0], 1'b1};
        end else begin
            o_rem = w_shift[DIVISOR_W-1:0];
            o_q   = {i_q[DIVIDEND_W-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/seq_restoring_divider.sv
// Multi-cycle unsigned restoring divider with a start/done handshake.
// One quotient bit per clock; divide-by-zero completes immediately with an error flag.
module seq_restoring_divider
    import seq_restoring_divider_pkg::*;
#(
    parameter int DIVIDEND_W = DEF_DIVIDEND_W,
    parameter int DIVISOR_W  = DEF_DIVISOR_W
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [DIVIDEND_W-1:0] dividend,
    input  logic [DIVISOR_W-1:0]  divisor,
    output logic                  busy,
    output logic                  done,
    output logic [DIVIDEND_W-1:0] quotient,
    output logic [DIVISOR_W-1:0]  remainder,
    output logic                  div_by_zero
);

    localparam int                CNT_W     = cnt_width(DIVIDEND_W);
    localparam logic [CNT_W-1:0]  LAST_ITER = CNT_W'(DIVIDEND_W - 1);

    state_t                  r_state;
    state_t                  w_state_next;
    logic [DIVISOR_W-1:0]    r_rem;
    logic [DIVIDEND_W-1:0]   r_q;
    logic [DIVISOR_W-1:0]    r_divisor;
    logic [CNT_W-1:0]        r_cnt;
    logic [DIVISOR_W-1:0]    w_rem_next;
    logic [DIVIDEND_W-1:0]   w_q_next;
    logic                    w_accept;
    logic                    w_zero;
    logic                    w_last_iter;

    assign w_zero      = (divisor == {DIVISOR_W{1'b0}});
    assign w_last_iter = (r_state == ST_BUSY) && (r_cnt == LAST_ITER);

    div_step #(
        .DIVIDEND_W (DIVIDEND_W),
        .DIVISOR_W  (DIVISOR_W)
    ) u_div_step (
        .i_rem     (r_rem),
        .i_q       (r_q),
        .i_divisor (r_divisor),
        .o_rem     (w_rem_next),
        .o_q       (w_q_next)
    );

    // Next-state logic: a request is accepted from IDLE or from the DONE cycle.
    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        case (r_state)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    w_accept     = 1'b1;
                    w_state_next = w_zero ? ST_DONE : ST_BUSY;
                end else begin
                    w_state_next = ST_IDLE;
                end
            end
            ST_BUSY: begin
                if (r_cnt == LAST_ITER) begin
                    w_state_next = ST_DONE;
                end else begin
                    w_state_next = ST_BUSY;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // State register plus registered busy/done derived from the next state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            r_state <= w_state_next;
            busy    <= (w_state_next == ST_BUSY);
            done    <= (w_state_next == ST_DONE);
        end
    end

    // Operand capture on acceptance, then one restoring iteration per edge while busy.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rem     <= {DIVISOR_W{1'b0}};
            r_q       <= {DIVIDEND_W{1'b0}};
            r_divisor <= {DIVISOR_W{1'b0}};
            r_cnt     <= {CNT_W{1'b0}};
        end else if (w_accept) begin
            r_rem     <= {DIVISOR_W{1'b0}};
            r_q       <= dividend;
            r_divisor <= divisor;
            r_cnt     <= {CNT_W{1'b0}};
        end else if (r_state == ST_BUSY) begin
            r_rem     <= w_rem_next;
            r_q       <= w_q_next;
            r_cnt     <= r_cnt + CNT_W'(1);
        end else begin
            r_rem     <= r_rem;
            r_q       <= r_q;
            r_divisor <= r_divisor;
            r_cnt     <= r_cnt;
        end
    end

    // Result registers load only on entry to DONE and hold until the next result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            quotient    <= {DIVIDEND_W{1'b0}};
            remainder   <= {DIVISOR_W{1'b0}};
            div_by_zero <= 1'b0;
        end else if (w_accept && w_zero) begin
            quotient    <= {DIVIDEND_W{1'b1}};
            remainder   <= {DIVISOR_W{1'b0}};
            div_by_zero <= 1'b1;
        end else if (w_last_iter) begin
            quotient    <= w_q_next;
            remainder   <= w_rem_next;
            div_by_zero <= 1'b0;
        end else begin
            quotient    <= quotient;
            remainder   <= remainder;
            div_by_zero <= div_by_zero;
        end
    end

endmodule
